// File: rtl/bin_xfer_ctrl.sv
// bin_xfer_ctrl: moves one bin of clauses between the clause RAM and the
// clause array. A load streams RAM words base..base+N-1 into array rows
// 0..N-1; an update streams array rows 0..N-1 back to the same RAM words.
// Both RAM and array reads have one cycle of latency, so each direction
// ends with a drain state that retires the last in-flight word.
module bin_xfer_ctrl #(
  parameter int NUM_CLAUSES_A_BIN  = 8,
  parameter int WIDTH_BIN_ID       = 10,
  parameter int WIDTH_CLAUSES      = 16,
  parameter int ADDR_WIDTH_CLAUSES = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_load_i,
  input  logic                          start_update_i,
  input  logic [WIDTH_BIN_ID-1:0]       bin_id_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_o,
  output logic                          ram_we_o,
  output logic [WIDTH_CLAUSES-1:0]      ram_din_o,
  input  logic [WIDTH_CLAUSES-1:0]      ram_dout_i,
  output logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o,
  output logic [WIDTH_CLAUSES-1:0]      clause_o,
  output logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o,
  input  logic [WIDTH_CLAUSES-1:0]      clause_i
);

  localparam int N  = NUM_CLAUSES_A_BIN;
  localparam int A  = ADDR_WIDTH_CLAUSES;
  localparam int KW = $clog2(NUM_CLAUSES_A_BIN) + 1;
  localparam int AW = WIDTH_BIN_ID + KW + ADDR_WIDTH_CLAUSES;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_DRAIN,
    UPDATE,
    UPDATE_DRAIN,
    DONE
  } state_t;

  state_t                  state, state_n;
  logic [KW-1:0]           k, k_n;
  logic [WIDTH_BIN_ID-1:0] bin_q, bin_n;

  logic                    busy_n, done_n, we_n;
  logic [A-1:0]            addr_n, addr_k, addr_km1;
  logic [N-1:0]            wr_n, rd_n, hot_k, hot_km1;

  // Next-state logic: starts are only looked at in IDLE, load beats update,
  // and k runs one past the last row so the drain states can reuse k-1.
  always_comb begin
    state_n = state;
    k_n     = k;
    bin_n   = bin_q;
    case (state)
      IDLE: begin
        if (start_load_i) begin
          state_n = LOAD;
          k_n     = '0;
          bin_n   = bin_id_i;
        end else if (start_update_i) begin
          state_n = UPDATE;
          k_n     = '0;
          bin_n   = bin_id_i;
        end
      end
      LOAD: begin
        k_n = k + KW'(1);
        if (k == KW'(N - 1)) state_n = LOAD_DRAIN;
      end
      LOAD_DRAIN: state_n = DONE;
      UPDATE: begin
        k_n = k + KW'(1);
        if (k == KW'(N - 1)) state_n = UPDATE_DRAIN;
      end
      UPDATE_DRAIN: state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe; addresses wrap modulo the RAM size.
  always_comb begin
    addr_k   = A'(AW'(bin_n) * AW'(N) + AW'(k_n));
    addr_km1 = A'(AW'(bin_n) * AW'(N) + AW'(k_n) - AW'(1));
    hot_k    = N'(1) << k_n;
    hot_km1  = N'(1) << (k_n - KW'(1));
    busy_n   = (state_n != IDLE);
    done_n   = (state_n == DONE);
    we_n     = 1'b0;
    addr_n   = '0;
    wr_n     = '0;
    rd_n     = '0;
    case (state_n)
      LOAD: begin
        addr_n = addr_k;
        if (k_n != '0) wr_n = hot_km1;
      end
      LOAD_DRAIN: wr_n = hot_km1;
      UPDATE: begin
        rd_n = hot_k;
        if (k_n != '0) begin
          we_n   = 1'b1;
          addr_n = addr_km1;
        end
      end
      UPDATE_DRAIN: begin
        we_n   = 1'b1;
        addr_n = addr_km1;
      end
      default: ;
    endcase
  end

  // State, counter, latched bin and all control outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      bin_q       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      wr_carray_o <= '0;
      rd_carray_o <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      bin_q       <= bin_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      ram_addr_o  <= addr_n;
      ram_we_o    <= we_n;
      wr_carray_o <= wr_n;
      rd_carray_o <= rd_n;
    end
  end

  // Read data only exists in the cycle after its address/strobe, so the data
  // buses forward it, qualified by their registered strobes (zero otherwise).
  assign clause_o  = (wr_carray_o != '0) ? ram_dout_i : '0;
  assign ram_din_o = ram_we_o ? clause_i : '0;

endmodule

// File: tb/tb_bin_xfer_ctrl.sv
// tb_bin_xfer_ctrl: directed bench for bin_xfer_ctrl with N=8, 9-bit RAM
// address. Models a synchronous clause RAM and a clause array whose row r
// reads back 0xA0+r; outputs are sampled 1 time unit after each rising edge.
module tb_bin_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load_i, start_update_i;
  logic [9:0]  bin_id_i;
  logic        busy_o, done_o, ram_we_o;
  logic [8:0]  ram_addr_o;
  logic [15:0] ram_din_o, ram_dout_i, clause_o, clause_i;
  logic [7:0]  wr_carray_o, rd_carray_o;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] mem [512];
  logic        written [512];

  always #5 clk = ~clk;

  bin_xfer_ctrl #(
    .NUM_CLAUSES_A_BIN (8),
    .WIDTH_BIN_ID      (10),
    .WIDTH_CLAUSES     (16),
    .ADDR_WIDTH_CLAUSES(9)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_load_i  (start_load_i),
    .start_update_i(start_update_i),
    .bin_id_i      (bin_id_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .ram_addr_o    (ram_addr_o),
    .ram_we_o      (ram_we_o),
    .ram_din_o     (ram_din_o),
    .ram_dout_i    (ram_dout_i),
    .wr_carray_o   (wr_carray_o),
    .clause_o      (clause_o),
    .rd_carray_o   (rd_carray_o),
    .clause_i      (clause_i)
  );

  // Preset RAM content: word a holds 0x1000 + a - 24, so RAM[24+i] = 0x1000+i.
  function automatic logic [15:0] golden(input logic [8:0] a);
    return 16'h1000 + 16'(a) - 16'd24;
  endfunction

  // Clause array content: row r reads back as 0xA0 + r.
  function automatic logic [15:0] row_data(input logic [7:0] rd);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (rd[i]) r = 16'h00A0 + 16'(i);
    return r;
  endfunction

  // Synchronous RAM and clause array models with one cycle read latency.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 512; i++) written[i] <= 1'b0;
    end else if (ram_we_o) begin
      mem[ram_addr_o]     <= ram_din_o;
      written[ram_addr_o] <= 1'b1;
    end
    ram_dout_i <= written[ram_addr_o] ? mem[ram_addr_o] : golden(ram_addr_o);
    clause_i   <= row_data(rd_carray_o);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic upd, input logic [9:0] bin);
    start_load_i   = load;
    start_update_i = upd;
    bin_id_i       = bin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, " done"}, 32'(done_o), 32'd0);
    checkOutput({tag, " addr"}, 32'(ram_addr_o), 32'd0);
    checkOutput({tag, " we"}, 32'(ram_we_o), 32'd0);
    checkOutput({tag, " din"}, 32'(ram_din_o), 32'd0);
    checkOutput({tag, " wr"}, 32'(wr_carray_o), 32'd0);
    checkOutput({tag, " rd"}, 32'(rd_carray_o), 32'd0);
    checkOutput({tag, " clause"}, 32'(clause_o), 32'd0);
  endtask

  // Full load of one bin: start edge, N load cycles, drain, done, idle.
  task automatic runLoad(input string name, input logic [9:0] bin, input logic [8:0] base,
                         input logic with_upd, input logic pulse_upd);
    logic [7:0] exp_wr;
    applyStimulus(1'b1, with_upd, bin);
    tick();
    applyStimulus(1'b0, 1'b0, bin);
    for (int k = 0; k < 8; k++) begin
      exp_wr = (k == 0) ? 8'h00 : 8'(8'h01 << (k - 1));
      checkOutput($sformatf("%s addr k=%0d", name, k), 32'(ram_addr_o), 32'(9'(base + 9'(k))));
      checkOutput($sformatf("%s we k=%0d", name, k), 32'(ram_we_o), 32'd0);
      checkOutput($sformatf("%s busy k=%0d", name, k), 32'(busy_o), 32'd1);
      checkOutput($sformatf("%s done k=%0d", name, k), 32'(done_o), 32'd0);
      checkOutput($sformatf("%s rd k=%0d", name, k), 32'(rd_carray_o), 32'd0);
      checkOutput($sformatf("%s wr k=%0d", name, k), 32'(wr_carray_o), 32'(exp_wr));
      if (k > 0)
        checkOutput($sformatf("%s clause k=%0d", name, k), 32'(clause_o), 32'(golden(9'(base + 9'(k - 1)))));
      if (pulse_upd && k == 3) applyStimulus(1'b0, 1'b1, 10'd7);
      else applyStimulus(1'b0, 1'b0, bin);
      tick();
    end
    checkOutput({name, " drain wr"}, 32'(wr_carray_o), 32'h80);
    checkOutput({name, " drain clause"}, 32'(clause_o), 32'(golden(9'(base + 9'd7))));
    checkOutput({name, " drain we"}, 32'(ram_we_o), 32'd0);
    checkOutput({name, " drain done"}, 32'(done_o), 32'd0);
    tick();
    checkOutput({name, " done pulse"}, 32'(done_o), 32'd1);
    checkOutput({name, " done busy"}, 32'(busy_o), 32'd1);
    checkOutput({name, " done wr"}, 32'(wr_carray_o), 32'd0);
    checkOutput({name, " done we"}, 32'(ram_we_o), 32'd0);
    tick();
    checkOutput({name, " idle done"}, 32'(done_o), 32'd0);
    checkOutput({name, " idle busy"}, 32'(busy_o), 32'd0);
    checkOutput({name, " idle rd"}, 32'(rd_carray_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 10'd0);
    #2;
    checkAllZero("reset");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkOutput("post-reset busy", 32'(busy_o), 32'd0);

    $display("[TB] load bin 3");
    runLoad("load3", 10'd3, 9'd24, 1'b0, 1'b0);

    $display("[TB] update bin 5");
    applyStimulus(1'b0, 1'b1, 10'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 10'd5);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("upd rd k=%0d", k), 32'(rd_carray_o), 32'(8'(8'h01 << k)));
      checkOutput($sformatf("upd wr k=%0d", k), 32'(wr_carray_o), 32'd0);
      checkOutput($sformatf("upd we k=%0d", k), 32'(ram_we_o), (k == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("upd busy k=%0d", k), 32'(busy_o), 32'd1);
      if (k > 0) begin
        checkOutput($sformatf("upd addr k=%0d", k), 32'(ram_addr_o), 32'(40 + k - 1));
        checkOutput($sformatf("upd din k=%0d", k), 32'(ram_din_o), 32'(16'h00A0 + 16'(k - 1)));
      end
      tick();
    end
    checkOutput("upd drain we", 32'(ram_we_o), 32'd1);
    checkOutput("upd drain addr", 32'(ram_addr_o), 32'd47);
    checkOutput("upd drain din", 32'(ram_din_o), 32'h00A7);
    checkOutput("upd drain rd", 32'(rd_carray_o), 32'd0);
    tick();
    checkOutput("upd done pulse", 32'(done_o), 32'd1);
    checkOutput("upd done we", 32'(ram_we_o), 32'd0);
    tick();
    checkOutput("upd idle busy", 32'(busy_o), 32'd0);
    checkOutput("upd idle done", 32'(done_o), 32'd0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("upd ram[%0d]", 40 + i), 32'(mem[40 + i]), 32'(16'h00A0 + 16'(i)));

    $display("[TB] load and update together, bin 1");
    runLoad("both1", 10'd1, 9'd8, 1'b1, 1'b0);

    $display("[TB] load bin 1023 with address wrap");
    runLoad("load1023", 10'd1023, 9'd504, 1'b0, 1'b0);

    $display("[TB] update pulse during load");
    runLoad("ignore", 10'd3, 9'd24, 1'b0, 1'b1);

    $display("[TB] reset during load");
    applyStimulus(1'b1, 1'b0, 10'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 10'd2);
    repeat (4) tick();
    checkOutput("abort addr k=4", 32'(ram_addr_o), 32'd20);
    #2 rst = 1'b0;
    #1;
    checkAllZero("abort");
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("abort hold done %0d", i), 32'(done_o), 32'd0);
      checkOutput($sformatf("abort hold busy %0d", i), 32'(busy_o), 32'd0);
    end
    rst = 1'b1;
    tick();
    checkOutput("abort released done", 32'(done_o), 32'd0);
    runLoad("reload2", 10'd2, 9'd16, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin_xfer_ctrl.md
BIN_XFER_CTRL -- requirements
Module: bin_xfer_ctrl

Interface
REQ-001 Parameters SHALL be: NUM_CLAUSES_A_BIN, default 8, clauses per bin; WIDTH_BIN_ID, default 10, bin id width; WIDTH_CLAUSES, default 16, clause word width; ADDR_WIDTH_CLAUSES, default 9, clause RAM address width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_load_i  in  1  request to copy bin bin_id_i from RAM into the clause array
- start_update_i  in  1  request to copy the clause array back into RAM for bin bin_id_i
- bin_id_i  in  WIDTH_BIN_ID  target bin; sampled with a start
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse marking transfer completion
- ram_addr_o  out  ADDR_WIDTH_CLAUSES  clause RAM address
- ram_we_o  out  1  clause RAM write enable
- ram_din_o  out  WIDTH_CLAUSES  clause RAM write data
- ram_dout_i  in  WIDTH_CLAUSES  clause RAM read data, valid 1 cycle after address
- wr_carray_o  out  NUM_CLAUSES_A_BIN  one-hot clause array row write strobe
- clause_o  out  WIDTH_CLAUSES  clause array write data
- rd_carray_o  out  NUM_CLAUSES_A_BIN  one-hot clause array row read strobe
- clause_i  in  WIDTH_CLAUSES  clause array read data, valid 1 cycle after rd_carray_o

Function
REQ-003 States SHALL be IDLE, LOAD, LOAD_DRAIN, UPDATE, UPDATE_DRAIN, DONE.
REQ-004 In IDLE, a sampled start SHALL latch bin_id_i, clear index counter k to 0 and enter LOAD (start_load_i) or UPDATE (start_update_i).
REQ-005 If start_load_i and start_update_i are both high in IDLE, load SHALL win and the update request SHALL be dropped.
REQ-006 Starts while not in IDLE SHALL be ignored with no side effect.
REQ-007 Base address SHALL be bin_id*NUM_CLAUSES_A_BIN, computed at full precision and truncated to ADDR_WIDTH_CLAUSES bits; ram_addr_o = base+k, truncated identically (wrap-around permitted).
REQ-008 LOAD, cycle k (0..N-1): ram_addr_o=base+k, ram_we_o=0; wr_carray_o bit k-1 high with clause_o=ram_dout_i when k>=1; k increments; after k=N-1 go to LOAD_DRAIN.
REQ-009 LOAD_DRAIN: wr_carray_o bit N-1 high, clause_o=ram_dout_i; next state DONE.
REQ-010 UPDATE, cycle k (0..N-1): rd_carray_o bit k high; when k>=1 ram_we_o=1, ram_addr_o=base+k-1, ram_din_o=clause_i; after k=N-1 go to UPDATE_DRAIN.
REQ-011 UPDATE_DRAIN: ram_we_o=1, ram_addr_o=base+N-1, ram_din_o=clause_i; next state DONE.
REQ-012 DONE: done_o=1 for exactly one cycle, then IDLE; a new start is accepted in the IDLE cycle that follows.
REQ-013 Start-sample edge to done_o SHALL be N+2 cycles (N+3 clock edges from start to return to IDLE).
REQ-014 busy_o SHALL be high in LOAD, LOAD_DRAIN, UPDATE, UPDATE_DRAIN and DONE, and low only in IDLE.
REQ-015 wr_carray_o and rd_carray_o SHALL each be zero or one-hot, never both nonzero in the same cycle; ram_we_o SHALL be 0 in IDLE, LOAD, LOAD_DRAIN and DONE.
REQ-016 k SHALL be $clog2(NUM_CLAUSES_A_BIN)+1 bits wide and must not overflow for N a power of two.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 While rst=0, state SHALL be IDLE, k=0, latched bin id=0, and every output SHALL be 0 immediately, regardless of clock.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no done_o pulse; after rst deasserts, the first start is honoured normally.

Verification
REQ-020 Load bin 3, N=8, RAM[24+i]=0x1000+i: addresses 24..31 on consecutive cycles; wr_carray_o=0x01..0x80 one cycle later with clause_o=0x1000..0x1007; done_o 10 cycles after the start edge.
REQ-021 Update bin 5, clause_i returns 0xA0+row: ram_we_o writes 0xA0..0xA7 to addresses 40..47; rd_carray_o leads each write by exactly one cycle.
REQ-022 start_load_i and start_update_i both high with bin 1: only a load of addresses 8..15 occurs; ram_we_o never asserts.
REQ-023 Bin 1023 with ADDR_WIDTH_CLAUSES=9: base 8184 truncates to 504; addresses 504..511 are issued.
REQ-024 start_update_i pulsed during a load: ignored; exactly one done_o; busy_o deasserts in the cycle after done_o.
REQ-025 rst driven low at load cycle k=4: all outputs 0 asynchronously, no done_o; a new load after release completes in 10 cycles.
